instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory read interface.
//  - Owns the program counter (PC) and drives the byte address to the combinational,
//    word-aligned instruction ROM. The ROM returns the word in the same cycle.
//  - Buffers {pc, instruction} pairs in a small FIFO and presents them to decode with
//    a valid/ready handshake.
//  - Accepts branch/jump redirects and halt requests from later pipeline stages.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  DEPTH     2              fetch FIFO entries; power of 2, >= 2
// PORTS
//  clk               in   1   single clock, rising edge
//  rst_n             in   1   synchronous, active-low reset
//  imem_pc           out  32  byte address to the instruction ROM; always equals pc_q
//  imem_instruction  in   32  ROM read data for imem_pc, valid in the same cycle
//  out_valid         out  1   FIFO head holds a valid entry
//  out_ready         in   1   decode accepts the head; pop when out_valid && out_ready
//  out_instr         out  32  head instruction
//  out_pc            out  32  head PC
//  redirect_valid    in   1   1-cycle request to load a new PC and flush the FIFO
//  redirect_pc       in   32  redirect target
//  halt_req          in   1   stop fetching; already-buffered entries drain normally
//  halted            out  1   1 while state == HALT
//  misaligned        out  1   1-cycle pulse the cycle after a redirect with target [1:0] != 0
// BEHAVIOUR
//  - Reset (rst_n == 0 at a clk edge, including mid-operation):
//    pc_q = RESET_PC, FIFO emptied, state = IDLE.
//    Outputs: out_valid = 0, out_instr = 0, out_pc = 0, halted = 0, misaligned = 0.
//  - FSM transitions:
//    IDLE -> RUN unconditionally, so no fetch occurs in the first cycle after reset release.
//    RUN  -> HALT on halt_req && !redirect_valid.
//    HALT -> RUN on redirect_valid; halt_req is ignored while in HALT.
//  - Fetch, in RUN with no redirect: if the FIFO is not full, or a pop happens in the same
//    cycle, push {pc_q, imem_instruction} and set pc_q <= pc_q + 4. Otherwise pc_q holds
//    (stall).
//  - Latency: the word fetched while pc_q == P appears at the FIFO head (out_pc == P) on
//    the next cycle if the FIFO was empty. With out_ready held at 1, throughput is 1 per cycle.
//  - PC arithmetic: 32-bit unsigned. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000. The ROM
//    applies its own address wrap; this block does not.
//  - Redirect has the highest priority, from any non-IDLE state:
//    FIFO flushed, including any push in that cycle; pc_q <= {redirect_pc[31:2], 2'b00}.
//    out_valid = 0 in the next cycle. A pop in the redirect cycle counts as a completed handshake.
//  - redirect_valid && halt_req in the same cycle: redirect wins, and the state is RUN.
//  - Misaligned redirect: the target is force-aligned, and misaligned pulses exactly one cycle.
//  - Head stability: while out_valid && !out_ready, out_instr and out_pc are held stable.
//  - FIFO boundaries:
//    full with no pop -> no push, PC stalls;
//    empty -> out_valid = 0, and out_instr/out_pc keep their last value;
//    full with pop -> push and pop in the same cycle, count unchanged.
//  - halted rises the cycle after halt_req is accepted. It does not wait for the FIFO to drain.
// STRUCTURE
//  - Package riscv_fetch_pkg holds:
//    fetch_state_t enum {IDLE, RUN, HALT}; INSTR_W = 32; XLEN = 32;
//    PC_INCR = 4; typedef fetch_entry_t {pc, instr}.
//  - Sub-module fetch_fifo: synchronous FIFO (DEPTH, width 64) with push, pop, flush,
//    full, empty, and a registered head. flush has priority over push.
//  - The top level holds pc_q, the FSM, redirect/halt arbitration and the misaligned pulse.
// TESTING (ROM model: word at byte address 4*i holds 32'h100 + i)
//  1. Reset release, out_ready = 1: first out_valid at cycle 2 after release, with
//     out_pc = 0, out_instr = 32'h100; then out_pc 4, 8, 12 on consecutive cycles.
//  2. out_ready = 0 for 5 cycles, DEPTH = 2: FIFO holds PCs 0 and 4; imem_pc stalls at 8;
//     head stays pc 0. Raising out_ready gives 0, 4, 8 with no gap or duplicate.
//  3. redirect_valid with redirect_pc = 32'h40 while the FIFO is full: out_valid = 0 in the
//     next cycle, then out_pc = 32'h40, out_instr = 32'h110; no stale entry is emitted.
//  4. redirect_pc = 32'h43: misaligned = 1 for exactly one cycle; next fetch uses
//     pc 32'h40; then pc 32'h44.
//  5. halt_req at pc 8: buffered entries drain, halted = 1, imem_pc frozen.
//     halt_req && redirect_valid(32'h20) together: no halt; fetch resumes at 32'h20.
//  6. rst_n low for one cycle mid-stream (FIFO full, PC 32'hFFFF_FFF8): all outputs return
//     to reset values and the restart matches test 1. Separately, a PC sequence
//     32'hFFFF_FFFC -> 32'h0 checks the wrap.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its FIFO.
package riscv_fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // pc sits in the upper half so a packed entry reads {pc, instr}
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = XLEN + INSTR_W;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] target);
    return {target[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a registered head word; flush outranks push, and the
// head keeps its last value once the FIFO runs empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    rd_ptr_inc;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] head_q;
  logic             do_pop;
  logic             do_push;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign rd_ptr_inc = rd_ptr_q + PW'(1);
  assign head       = head_q;

  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_inc;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
      // The head tracks whichever entry will be oldest after this cycle.
      if (do_pop) begin
        if (count_q >= CW'(2)) begin
          head_q <= mem[rd_ptr_inc];
        end else if (do_push) begin
          head_q <= din;
        end
      end else if (do_push && empty) begin
        head_q <= din;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads the combinational ROM and
// queues {pc, instr} pairs for decode, honouring redirects and halt requests.
module instruction_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        misaligned
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_HALT = HALT;

  logic [1:0]         state_q;
  logic [1:0]         state_next;
  logic [XLEN-1:0]    pc_q;
  logic               misaligned_q;

  logic               redirect_take;
  logic               pop;
  logic               fetch;
  logic               fifo_full;
  logic               fifo_empty;
  fetch_entry_t       push_entry;
  logic [ENTRY_W-1:0] head_bits;
  fetch_entry_t       head_entry;

  assign redirect_take = redirect_valid && (state_q != S_IDLE);
  assign pop           = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO keeps streaming.
  assign fetch         = (state_q == S_RUN) && !redirect_valid && (!fifo_full || pop);

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_instruction;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch),
    .pop   (pop),
    .flush (redirect_take),
    .din   (push_entry),
    .head  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_entry = fetch_entry_t'(head_bits);

  assign imem_pc    = pc_q;
  assign out_valid  = !fifo_empty;
  assign out_pc     = head_entry.pc;
  assign out_instr  = head_entry.instr;
  assign halted     = (state_q == S_HALT);
  assign misaligned = misaligned_q;

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE: state_next = S_RUN;
      S_RUN: begin
        if (halt_req && !redirect_valid) begin
          state_next = S_HALT;
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          state_next = S_RUN;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_next;
      misaligned_q <= redirect_take && (redirect_pc[1:0] != 2'b00);
      if (redirect_take) begin
        pc_q <= align_pc(redirect_pc);
      end else if (fetch) begin
        pc_q <= pc_q + PC_INCR;
      end
    end
  end

endmodule
